alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width.
REQ-002 Parameter OP_WIDTH, default 3, ALU opcode width.
REQ-003 Clock and reset: one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 req_valid  input  2  per-requester request valid; bit i belongs to requester i.
REQ-007 req_ready  output  2  per-requester accept; a transfer occurs when req_valid[i] & req_ready[i].
REQ-008 req0_op, req1_op  input  OP_WIDTH each  opcode from requester 0 or 1.
REQ-009 req0_a, req0_b, req1_a, req1_b  input  WIDTH each  operands op1 and op2 per requester.
REQ-010 rsp_valid  output  2  result valid, one-hot, to the granted requester.
REQ-011 rsp_ready  input  2  per-requester result accept.
REQ-012 rsp_data  output  WIDTH  registered ALU result, shared by both requesters.

Function
REQ-013 FSM states: IDLE, EXEC and RESP, with IDLE as the reset state.
REQ-014 IDLE behaviour:
- req_ready[g] is 1 only for the arbitration winner g, and only when req_valid[g]=1; all other ready bits are 0.
- Winner selection is round-robin by priority pointer ptr.
- If exactly one valid, that requester wins.
- If both valid, requester ptr wins.
REQ-015 On a transfer:
- Latch op, a, b and grant id g.
- Set ptr to ~g.
- Next state is EXEC.
REQ-016 In EXEC, req_ready=0; the internal alu sub-module computes from the latched operands; the result is registered into rsp_data; next state is RESP.
REQ-017 In RESP:
- rsp_valid[g]=1 and the other bit is 0.
- rsp_data holds stable until rsp_ready[g]=1, then the next state is IDLE.
- rsp_ready on the non-granted bit is ignored.
REQ-018 Latency: with rsp_ready[g] held high, rsp_valid[g] rises exactly 2 cycles after the transfer edge; minimum issue interval is 3 cycles.
REQ-019 Arithmetic follows the ALU definition:
- 001 add, 010 sub, 011 and, 100 or, 101 xor.
- Add and sub are modulo 2^WIDTH; carry and borrow are discarded.
- Opcodes 000, 110 and 111 yield 0.
REQ-020 Dropping req_valid before a transfer cancels the request with no side effect; req_ready is combinational on req_valid in IDLE only.
REQ-021 Holding rsp_ready low stalls indefinitely in RESP; no new request is accepted while stalled.
REQ-022 Operand inputs are sampled only on the transfer edge; later changes do not affect the result.

Reset
REQ-023 On rst=1 at a clock edge:
- State goes to IDLE and ptr to 0.
- rsp_valid=0, rsp_data=0, req_ready=0 for that cycle.
- Latched op, operands and grant are cleared to 0.
REQ-024 Reset mid-operation (EXEC or RESP) abandons the operation; no rsp_valid is produced for it.

Configuration
REQ-025 Macro ALU_ARBITER_ERR_EN adds output rsp_err (1 bit).
- With the macro: rsp_err is registered alongside rsp_data, is 1 in RESP when the latched opcode is 000, 110 or 111, else 0, and resets to 0.
- Without the macro: the port and its logic do not exist; all other behaviour is identical.

Structure
REQ-026 A shared package/include holds:
- Opcode constants ALU_OP_ADD=001, ALU_OP_SUB=010, ALU_OP_AND=011, ALU_OP_OR=100, ALU_OP_XOR=101.
- FSM state encodings.
- Default WIDTH/OP_WIDTH values.
REQ-027 The design instantiates exactly one sub-module, the existing alu (WIDTH, OP_WIDTH passed through); the arbiter contains no duplicate arithmetic.

Verification
REQ-028 Single request: rst, then req_valid=01, req0_op=001, a=0x7F, b=0x01, rsp_ready=11 -> req_ready=01 same cycle; rsp_valid=01, rsp_data=0x80 two cycles later.
REQ-029 Contention: both valid from reset (ptr=0); req0 sub 0x05-0x07, req1 xor 0xF0^0x0F.
- First grant is req0, giving rsp_data=0xFE.
- Next grant is req1, giving rsp_data=0xFF.
- ptr alternates to give a third grant to req0.
REQ-030 Backpressure: rsp_ready[g]=0 for 5 cycles in RESP -> rsp_valid and rsp_data are stable, req_ready=00 throughout; completes on the cycle rsp_ready rises.
REQ-031 Invalid opcode 111 with a=0xAA, b=0x55 -> rsp_data=0x00; with ALU_ARBITER_ERR_EN, rsp_err=1; a following valid op gives rsp_err=0.
REQ-032 Reset mid-op: assert rst during EXEC -> next cycle rsp_valid=00, rsp_data=0; no stale response afterwards; ptr=0 so req0 wins the next contention.
REQ-033 Wrap-around: 0xFF add 0x01 -> 0x00; 0x00 sub 0x01 -> 0xFF.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcodes, FSM states, default widths.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package alu_arbiter_pkg;

  localparam int ALU_ARB_WIDTH    = 8;
  localparam int ALU_ARB_OP_WIDTH = 3;

  localparam logic [2:0] ALU_OP_ADD = 3'b001;
  localparam logic [2:0] ALU_OP_SUB = 3'b010;
  localparam logic [2:0] ALU_OP_AND = 3'b011;
  localparam logic [2:0] ALU_OP_OR  = 3'b100;
  localparam logic [2:0] ALU_OP_XOR = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU: add/sub (modulo 2^WIDTH), and/or/xor; unknown opcodes give zero.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller registers the result.
module alu
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH    = ALU_ARB_WIDTH,
  parameter int OP_WIDTH = ALU_ARB_OP_WIDTH
) (
  input  logic [OP_WIDTH-1:0] op,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  output logic [WIDTH-1:0]    y
);

  // Opcode decode; carry/borrow fall off the top of the WIDTH-bit result.
  always_comb begin
    y = '0;
    case (op)
      OP_WIDTH'(ALU_OP_ADD): y = a + b;
      OP_WIDTH'(ALU_OP_SUB): y = a - b;
      OP_WIDTH'(ALU_OP_AND): y = a & b;
      OP_WIDTH'(ALU_OP_OR):  y = a | b;
      OP_WIDTH'(ALU_OP_XOR): y = a ^ b;
      default:               y = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter granting one of two requesters access to a shared ALU.
// Latency: response valid two cycles after the accept cycle; one op in flight, issue every 3 cycles minimum.
// Backpressure: holds in RESP with stable data until rsp_ready of the granted requester; optional rsp_err via ALU_ARBITER_ERR_EN.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH    = ALU_ARB_WIDTH,
  parameter int OP_WIDTH = ALU_ARB_OP_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [OP_WIDTH-1:0] req0_op,
  input  logic [WIDTH-1:0]    req0_a,
  input  logic [WIDTH-1:0]    req0_b,
  input  logic [OP_WIDTH-1:0] req1_op,
  input  logic [WIDTH-1:0]    req1_a,
  input  logic [WIDTH-1:0]    req1_b,
  output logic [1:0]          rsp_valid,
  input  logic [1:0]          rsp_ready,
  output logic [WIDTH-1:0]    rsp_data
`ifdef ALU_ARBITER_ERR_EN
  ,
  output logic                rsp_err
`endif
);

  state_t              state;
  state_t              state_nxt;
  logic                ptr;
  logic                gnt;
  logic                win;
  logic                xfer;
  logic [OP_WIDTH-1:0] lat_op;
  logic [WIDTH-1:0]    lat_a;
  logic [WIDTH-1:0]    lat_b;
  logic [WIDTH-1:0]    alu_y;

  alu #(
    .WIDTH    (WIDTH),
    .OP_WIDTH (OP_WIDTH)
  ) u_alu (
    .op (lat_op),
    .a  (lat_a),
    .b  (lat_b),
    .y  (alu_y)
  );

  // Winner: a lone requester wins outright; on a tie the pointer decides.
  always_comb begin
    win = 1'b0;
    if (req_valid == 2'b11) begin
      win = ptr;
    end else begin
      win = req_valid[1];
    end
  end

  // Next state and handshake outputs; ready/valid are forced low while reset is asserted.
  always_comb begin
    state_nxt = state;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    xfer      = 1'b0;
    case (state)
      IDLE: begin
        if (!rst && (req_valid != 2'b00)) begin
          req_ready = win ? 2'b10 : 2'b01;
          xfer      = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        state_nxt = RESP;
      end
      RESP: begin
        if (!rst) begin
          rsp_valid = gnt ? 2'b10 : 2'b01;
        end
        if (rsp_ready[gnt]) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture the winning request on accept, and the ALU result during EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= 1'b0;
      gnt      <= 1'b0;
      lat_op   <= '0;
      lat_a    <= '0;
      lat_b    <= '0;
      rsp_data <= '0;
    end else begin
      if (xfer) begin
        lat_op <= win ? req1_op : req0_op;
        lat_a  <= win ? req1_a  : req0_a;
        lat_b  <= win ? req1_b  : req0_b;
        gnt    <= win;
        ptr    <= ~win;
      end
      if (state == EXEC) begin
        rsp_data <= alu_y;
      end
    end
  end

`ifdef ALU_ARBITER_ERR_EN
  // Error flag: set alongside the result when the latched opcode is not one the ALU implements.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_err <= 1'b0;
    end else if (state == EXEC) begin
      rsp_err <= !((lat_op == OP_WIDTH'(ALU_OP_ADD)) || (lat_op == OP_WIDTH'(ALU_OP_SUB)) ||
                   (lat_op == OP_WIDTH'(ALU_OP_AND)) || (lat_op == OP_WIDTH'(ALU_OP_OR))  ||
                   (lat_op == OP_WIDTH'(ALU_OP_XOR)));
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed requests push expected responses, a monitor pops on each response handshake.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [2:0] req0_op, req1_op;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0] rsp_valid;
  logic [1:0] rsp_ready;
  logic [7:0] rsp_data;
`ifdef ALU_ARBITER_ERR_EN
  logic       rsp_err;
`endif

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(8), .OP_WIDTH(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req0_op   (req0_op),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req1_op   (req1_op),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data)
`ifdef ALU_ARBITER_ERR_EN
    ,
    .rsp_err   (rsp_err)
`endif
  );

  typedef struct packed {
    logic       g;
    logic [7:0] d;
    logic       e;
  } exp_t;

  exp_t sb[$];
  int   n_tot  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [1:0] oh(input logic g);
    return g ? 2'b10 : 2'b01;
  endfunction

  function automatic logic bad_op(input logic [2:0] op);
    return (op == 3'b000) || (op == 3'b110) || (op == 3'b111);
  endfunction

  // Monitor: every response handshake must match the oldest outstanding expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && ((rsp_valid & rsp_ready) != 2'b00)) begin
      if (sb.size() == 0) begin
        chk("stale_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rsp_valid", 32'(rsp_valid), 32'(oh(e.g)));
        chk("rsp_data", 32'(rsp_data), 32'(e.d));
`ifdef ALU_ARBITER_ERR_EN
        chk("rsp_err", 32'(rsp_err), 32'(e.e));
`endif
      end
    end
  end

  // Drive a request, wait (bounded) for the grant, check the winner, then scramble the winner's operands.
  task automatic send(input logic [1:0] vld,
                      input logic [2:0] op0, input logic [7:0] a0, input logic [7:0] b0,
                      input logic [2:0] op1, input logic [7:0] a1, input logic [7:0] b1,
                      input logic exp_g, input logic [7:0] exp_d);
    bit   got = 0;
    exp_t e;
    req0_op = op0; req0_a = a0; req0_b = b0;
    req1_op = op1; req1_a = a1; req1_b = b1;
    req_valid = vld;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (req_ready != 2'b00) got = 1;
    end
    chk(got ? "grant" : "grant_timeout", 32'(req_ready), 32'(oh(exp_g)));
    if (!got) begin
      req_valid = 2'b00;
    end else begin
      e.g = exp_g;
      e.d = exp_d;
      e.e = bad_op(exp_g ? op1 : op0);
      sb.push_back(e);
      @(posedge clk); #1;
      req_valid[exp_g] = 1'b0;
      if (exp_g) begin
        req1_op = 3'($urandom); req1_a = 8'($urandom); req1_b = 8'($urandom);
      end else begin
        req0_op = 3'($urandom); req0_a = 8'($urandom); req0_b = 8'($urandom);
      end
    end
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk); #1;
      if (sb.size() == 0 && rsp_valid == 2'b00) done = 1;
    end
    if (!done) chk("idle_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = 2'b11; rsp_ready = 2'b11;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
`ifdef ALU_ARBITER_ERR_EN
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
`endif
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 2'b00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    bit got;
    req0_op = '0; req0_a = '0; req0_b = '0;
    req1_op = '0; req1_a = '0; req1_b = '0;
    do_reset();

    // Single request with explicit latency checks.
    send(2'b01, ALU_OP_ADD, 8'h7F, 8'h01, 3'b000, 8'h00, 8'h00, 1'b0, 8'h80);
    @(negedge clk);
    chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("exec_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("lat_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("lat_rsp_data", 32'(rsp_data), 32'h80);
    wait_idle();

    // Contention from reset: req0, req1, req0.
    do_reset();
    send(2'b11, ALU_OP_SUB, 8'h05, 8'h07, ALU_OP_XOR, 8'hF0, 8'h0F, 1'b0, 8'hFE);
    send(2'b11, ALU_OP_AND, 8'h3C, 8'h0F, ALU_OP_XOR, 8'hF0, 8'h0F, 1'b1, 8'hFF);
    send(2'b11, ALU_OP_AND, 8'h3C, 8'h0F, ALU_OP_XOR, 8'hF0, 8'h0F, 1'b0, 8'h0C);
    req_valid = 2'b00;
    wait_idle();

    // Wrap-around, invalid opcodes, remaining ops.
    send(2'b10, 3'b000, 8'h00, 8'h00, ALU_OP_ADD, 8'hFF, 8'h01, 1'b1, 8'h00);
    send(2'b01, ALU_OP_SUB, 8'h00, 8'h01, 3'b000, 8'h00, 8'h00, 1'b0, 8'hFF);
    send(2'b01, 3'b111, 8'hAA, 8'h55, 3'b000, 8'h00, 8'h00, 1'b0, 8'h00);
    send(2'b10, 3'b000, 8'h00, 8'h00, ALU_OP_AND, 8'hF0, 8'h3C, 1'b1, 8'h30);
    send(2'b01, 3'b000, 8'h12, 8'h34, 3'b000, 8'h00, 8'h00, 1'b0, 8'h00);
    send(2'b10, 3'b000, 8'h00, 8'h00, 3'b110, 8'h12, 8'h34, 1'b1, 8'h00);
    send(2'b01, ALU_OP_OR, 8'hA0, 8'h05, 3'b000, 8'h00, 8'h00, 1'b0, 8'hA5);
    wait_idle();

    // Cancel in IDLE: ready follows valid combinationally; dropping valid leaves ptr (=1) untouched.
    req_valid = 2'b10;
    #1 chk("comb_ready", 32'(req_ready), 32'h2);
    req_valid = 2'b00;
    #1 chk("cancel_ready", 32'(req_ready), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("cancel_no_rsp", 32'(rsp_valid), 32'd0);
    end
    @(posedge clk); #1;
    send(2'b11, ALU_OP_XOR, 8'h0F, 8'hFF, ALU_OP_ADD, 8'h10, 8'h20, 1'b1, 8'h30);
    req_valid = 2'b00;
    wait_idle();

    // Backpressure: granted bit low for 5 cycles, other bit high and ignored.
    rsp_ready = 2'b10;
    send(2'b01, ALU_OP_OR, 8'hA0, 8'h05, 3'b000, 8'h00, 8'h00, 1'b0, 8'hA5);
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) got = 1;
    end
    chk("bp_rsp_seen", 32'(rsp_valid), 32'd1);
    req1_op = ALU_OP_ADD; req1_a = 8'h01; req1_b = 8'h01;
    req_valid = 2'b10;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_data", 32'(rsp_data), 32'hA5);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    req_valid = 2'b00; rsp_ready = 2'b11;
    @(posedge clk); #1;
    chk("bp_done", 32'(rsp_valid), 32'd0);
    chk("bp_drained", 32'(sb.size()), 32'd0);

    // Reset during EXEC: operation abandoned, ptr back to 0.
    send(2'b01, ALU_OP_ADD, 8'h01, 8'h02, 3'b000, 8'h00, 8'h00, 1'b0, 8'h03);
    rst = 1'b1;
    req0_op = ALU_OP_SUB; req0_a = 8'h09; req0_b = 8'h04;
    req1_op = ALU_OP_ADD; req1_a = 8'h01; req1_b = 8'h01;
    req_valid = 2'b11;
    @(negedge clk);
    chk("rst_exec_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_rsp_data", 32'(rsp_data), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    send(2'b11, ALU_OP_SUB, 8'h09, 8'h04, ALU_OP_ADD, 8'h01, 8'h01, 1'b0, 8'h05);
    req_valid = 2'b00;
    wait_idle();
    repeat (5) @(posedge clk);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
